// File: rtl/sipo_frame_ctrl.sv
// ----------------------------------------------------------------------------
// sipo_frame_ctrl
//   Serial-in / parallel-out frame sequencer. A frame_start pulse arms the
//   capture, after which every bit_valid strobe shifts serial_in into a
//   DATA_W-bit register. Once the last bit arrives, the completed word goes to
//   a one-entry valid/ready output buffer. Frames that stall for TIMEOUT
//   consecutive cycles, or that are restarted early, are dropped and reported
//   with a one-cycle frame_err pulse. A word that completes while the buffer
//   still holds an unconsumed word is dropped and sets the sticky overflow flag.
//
// Parameters
//   DATA_W     bits per word (>= 2)
//   MSB_FIRST  1: first received bit lands in out_data[DATA_W-1]; 0: in out_data[0]
//   TIMEOUT    consecutive SHIFT cycles without bit_valid before abort (>= 1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   frame_start  in   begin a new word capture (restarts an ongoing one)
//   serial_in    in   serial data, sampled when bit_valid=1 in SHIFT
//   bit_valid    in   serial_in holds a valid bit this cycle
//   out_data     out  completed word, stable while out_valid=1
//   out_valid    out  out_data holds an unconsumed word
//   out_ready    in   consumer accepts when out_valid & out_ready
//   busy         out  capture in progress (SHIFT state)
//   frame_err    out  one-cycle pulse: frame aborted (timeout or restart)
//   overflow     out  sticky: completed word dropped because buffer was full
//   ovf_clear    in   synchronous clear of overflow (a new drop wins)
// ----------------------------------------------------------------------------
module sipo_frame_ctrl #(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              serial_in,
   input  logic              bit_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              overflow,
   input  logic              ovf_clear
);

   localparam int CW = $clog2(DATA_W);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
   localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_sr;
   logic [DATA_W-1:0] w_sr_shift;
   logic [CW-1:0]     r_bit_cnt;
   logic [IW-1:0]     r_idle_cnt;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_frame_err;
   logic              r_overflow;
   logic              w_busy;
   logic              w_frame_err_nxt;
   logic              w_shift_bit;
   logic              w_complete;
   logic              w_timeout;
   logic              w_accept;

   assign w_shift_bit = (r_state == S_SHIFT) && bit_valid;
   assign w_complete  = w_shift_bit && (r_bit_cnt == LAST_BIT);
   // The idle count tracks cycles already spent idle, so the abort fires on
   // the TIMEOUT-th consecutive idle cycle.
   assign w_timeout   = (r_state == S_SHIFT) && !bit_valid && (r_idle_cnt == IDLE_LIM);
   assign w_accept    = r_out_valid && out_ready;
   assign w_sr_shift  = (MSB_FIRST != 0) ? {r_sr[DATA_W-2:0], serial_in}
                                         : {serial_in, r_sr[DATA_W-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_busy          = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_start) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            w_busy = 1'b1;
            if (frame_start) begin
               // A restart on the last-bit cycle still delivers the word and
               // is a clean back-to-back start, not an error.
               w_state_nxt     = S_SHIFT;
               w_frame_err_nxt = !w_complete;
            end else if (w_complete || w_timeout) begin
               w_state_nxt = S_IDLE;
            end
            if (w_timeout) w_frame_err_nxt = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_idle_cnt <= '0;
      end else if (frame_start) begin
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_idle_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
         if (bit_valid) begin
            r_sr       <= w_sr_shift;
            r_bit_cnt  <= w_complete ? '0 : r_bit_cnt + 1'b1;
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= w_timeout ? '0 : r_idle_cnt + 1'b1;
         end
      end
   end

   // A slot frees up in the same cycle the consumer takes the held word, so a
   // completion coinciding with a transfer still loads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_frame_err_nxt;
         if (w_complete && (!r_out_valid || w_accept)) begin
            r_out_data  <= w_sr_shift;
            r_out_valid <= 1'b1;
         end else if (w_accept) begin
            r_out_valid <= 1'b0;
         end
         if (w_complete && r_out_valid && !out_ready) r_overflow <= 1'b1;
         else if (ovf_clear)                          r_overflow <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = w_busy;
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl. Three instances share one stimulus:
// u0 (MSB first, TIMEOUT 255), u1 (LSB first), u2 (MSB first, TIMEOUT 4).
module tb_sipo_frame_ctrl;

   logic clk = 1'b0;
   logic reset, frame_start, serial_in, bit_valid, out_ready, ovf_clear;

   logic [7:0] d0, d1, d2;
   logic       v0, v1, v2, b0, b1, b2, e0, e1, e2, o0, o1, o2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sipo_frame_ctrl #(.DATA_W(8), .MSB_FIRST(1), .TIMEOUT(255)) u0 (
      .clk(clk), .reset(reset), .frame_start(frame_start), .serial_in(serial_in),
      .bit_valid(bit_valid), .out_data(d0), .out_valid(v0), .out_ready(out_ready),
      .busy(b0), .frame_err(e0), .overflow(o0), .ovf_clear(ovf_clear));

   sipo_frame_ctrl #(.DATA_W(8), .MSB_FIRST(0), .TIMEOUT(255)) u1 (
      .clk(clk), .reset(reset), .frame_start(frame_start), .serial_in(serial_in),
      .bit_valid(bit_valid), .out_data(d1), .out_valid(v1), .out_ready(out_ready),
      .busy(b1), .frame_err(e1), .overflow(o1), .ovf_clear(ovf_clear));

   sipo_frame_ctrl #(.DATA_W(8), .MSB_FIRST(1), .TIMEOUT(4)) u2 (
      .clk(clk), .reset(reset), .frame_start(frame_start), .serial_in(serial_in),
      .bit_valid(bit_valid), .out_data(d2), .out_valid(v2), .out_ready(out_ready),
      .busy(b2), .frame_err(e2), .overflow(o2), .ovf_clear(ovf_clear));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are looked at 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends w[7] first on consecutive bit_valid strobes.
   task automatic send_bits(input logic [7:0] w, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         bit_valid = 1'b1;
         serial_in = w[i];
         tick();
      end
      bit_valid = 1'b0;
      serial_in = 1'b0;
   endtask

   task automatic start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic frame(input logic [7:0] w);
      start();
      send_bits(w, 8);
   endtask

   initial begin
      reset = 1'b1; frame_start = 1'b0; serial_in = 1'b0; bit_valid = 1'b0;
      out_ready = 1'b0; ovf_clear = 1'b0;
      tick(); tick();
      chk("rst_valid", v0, 0);
      chk("rst_data", d0, 0);
      chk("rst_busy", b0, 0);
      chk("rst_err", e0, 0);
      chk("rst_ovf", o0, 0);
      reset = 1'b0;
      tick();

      // 1/2: A5 both bit orders, then LSB-first 03
      out_ready = 1'b1;
      start();
      chk("t1_busy", b0, 1);
      send_bits(8'hA5, 8);
      chk("t1_valid", v0, 1);
      chk("t1_data", d0, 8'hA5);
      chk("t1_idle", b0, 0);
      chk("t2_lsb_a5", d1, 8'hA5);
      tick();
      chk("t1_consumed", v0, 0);
      chk("t1_hold", d0, 8'hA5);
      frame(8'hC0);
      chk("t2_lsb_03", d1, 8'h03);
      chk("t2_msb_c0", d0, 8'hC0);
      tick();

      // 3: buffer full -> overflow, data held
      out_ready = 1'b0;
      frame(8'h3C);
      chk("t3_valid", v0, 1);
      chk("t3_data", d0, 8'h3C);
      frame(8'hFF);
      chk("t3_keep", d0, 8'h3C);
      chk("t3_keepv", v0, 1);
      chk("t3_ovf", o0, 1);
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      chk("t3_ovfclr", o0, 0);
      chk("t3_stall", v0, 1);
      out_ready = 1'b1;
      tick();
      chk("t3_drain", v0, 0);

      // 4: timeout on u2 (TIMEOUT=4)
      start();
      send_bits(8'hE0, 3);
      tick(); tick(); tick();
      chk("t4_pre_err", e2, 0);
      chk("t4_pre_busy", b2, 1);
      tick();
      chk("t4_err", e2, 1);
      chk("t4_busy", b2, 0);
      chk("t4_novalid", v2, 0);
      tick();
      chk("t4_pulse", e2, 0);
      frame(8'h96);
      chk("t4_data", d2, 8'h96);
      chk("t4_valid", v2, 1);
      tick();

      // 5: restart after 5 bits
      start();
      send_bits(8'hFF, 5);
      start();
      chk("t5_err", e0, 1);
      chk("t5_busy", b0, 1);
      send_bits(8'h5A, 8);
      chk("t5_noerr", e0, 0);
      chk("t5_data", d0, 8'h5A);
      chk("t5_valid", v0, 1);
      tick();

      // 6: async reset mid-frame with a buffered word
      out_ready = 1'b0;
      frame(8'h11);
      chk("t6_buf", v0, 1);
      start();
      send_bits(8'h0F, 4);
      #2 reset = 1'b1;
      #1;
      chk("t6_valid", v0, 0);
      chk("t6_data", d0, 0);
      chk("t6_busy", b0, 0);
      chk("t6_err", e0, 0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      frame(8'hC3);
      chk("t6_c3", d0, 8'hC3);
      chk("t6_c3v", v0, 1);

      // Back-to-back: frame_start on the last-bit cycle
      start();
      send_bits(8'h69, 7);
      bit_valid = 1'b1; serial_in = 1'b1; frame_start = 1'b1;
      tick();
      bit_valid = 1'b0; serial_in = 1'b0; frame_start = 1'b0;
      chk("b2b_data", d0, 8'h69);
      chk("b2b_valid", v0, 1);
      chk("b2b_busy", b0, 1);
      chk("b2b_noerr", e0, 0);
      send_bits(8'hE1, 8);
      chk("b2b_next", d0, 8'hE1);
      chk("b2b_ovf", o0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
